ad_ip_jesd204_tpl_adc_capture_ctrl: RTL and testbench
=====================================================

# ad_ip_jesd204_tpl_adc_capture_ctrl

Parametrised capture/synchronisation controller for the JESD204 TPL ADC path. It sits between the per-channel formatted sample outputs and the DMA interface. It replaces the simple armed toggle with four pieces of logic: a state machine, a selectable external-sync edge mode with a configurable synchroniser depth, bounded-length capture, and per-channel valid gating. Data passes through with a fixed one-cycle register stage.

## Interface
Parameters:
- NUM_CHANNELS, 1, converter channel count
- DATA_PATH_WIDTH, 1, samples per channel per beat
- BITS_PER_SAMPLE, 16, formatted sample width
- DMA_DATA_WIDTH, NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE, data bus width
- SYNC_STAGES, 2, external-sync synchroniser flops; legal range 2..4
- LENGTH_WIDTH, 16, width of capture_length and the beat counter
- COUNT_WIDTH, 8, width of sync_event_count

Ports:
- clk  in  1  sample clock; the single clock of the block
- reset  in  1  synchronous, active-high reset
- adc_sync  in  1  software arm/disarm pulse, one cycle
- adc_external_sync  in  1  asynchronous external trigger
- sync_mode  in  2  0 = external trigger ignored, 1 = rising edge, 2 = falling edge, 3 = either edge
- capture_length  in  LENGTH_WIDTH  valid beats per capture; 0 = unlimited
- chan_enable  in  NUM_CHANNELS  per-channel valid enable
- in_valid  in  1  input beat valid
- in_data  in  DMA_DATA_WIDTH  formatted channel data
- adc_valid  out  NUM_CHANNELS  gated per-channel valid
- adc_data  out  DMA_DATA_WIDTH  registered data
- adc_sync_status  out  1  high while ARMED
- adc_rst_sync  out  1  high while ARMED
- capture_done  out  1  one-cycle pulse on bounded-capture completion
- sync_event_count  out  COUNT_WIDTH  count of accepted triggers; wraps

## Operation
- States are FREE, ARMED, CAPTURE and DONE. Reset enters FREE.
- Gate is open in FREE and CAPTURE. Gate is closed in ARMED and DONE.
- adc_sync transitions:
  - FREE or DONE goes to ARMED.
  - ARMED goes to FREE (disarm).
  - CAPTURE goes to ARMED (abort and re-arm). The beat counter clears.
- External trigger path:
  - adc_external_sync passes through SYNC_STAGES flops, then a history flop.
  - A trigger is the synchronised edge selected by sync_mode.
  - The synchroniser and history flops run in every state, so a stale level never creates an edge on arming.
- In ARMED, a trigger moves the state to CAPTURE, clears the counter and increments sync_event_count.
- When sync_mode = 0, ARMED exits only on adc_sync.
- If adc_sync and a trigger occur in the same cycle while ARMED, adc_sync wins: the state goes to FREE and the count does not change.
- Triggers outside ARMED are ignored and not counted.
- Bounded capture (capture_length != 0):
  - In CAPTURE, the counter increments on each cycle with in_valid = 1.
  - When in_valid = 1 and counter == capture_length-1, that beat is still passed. The next state is DONE and capture_done pulses on the same edge.
- Unlimited capture (capture_length = 0): CAPTURE persists until adc_sync.
- capture_length is sampled continuously. Software keeps it stable outside FREE and DONE.
- Outputs:
  - adc_valid[i] <= in_valid & gate_open & chan_enable[i]
  - adc_data <= in_data, unconditionally
- Reset mid-capture: the state returns to FREE, the counter and sync_event_count clear, and the synchroniser flops clear to 0.

## Timing
- Reset values: adc_valid = 0, adc_data = 0, adc_sync_status = 0, adc_rst_sync = 0, capture_done = 0, sync_event_count = 0.
- Data and valid latency is 1 cycle, in_* to adc_*.
- Gating uses the state in the cycle the input beat is presented.
- Trigger latency: a level change on adc_external_sync that is set up before edge E0 puts the state in CAPTURE after edge E0+SYNC_STAGES. The first gated beat is the one presented in the cycle after that edge.
- adc_sync to adc_sync_status latency is 1 cycle.
- capture_done is high for exactly one cycle. It coincides with the cycle in which the state is DONE for the first time; the final beat's adc_valid is high in that same cycle.
- The counter cannot overflow: it stops at capture_length-1.

## Test plan
- Reset then free-run: in_valid = 1 with chan_enable = 2'b01 and NUM_CHANNELS = 2 -> adc_valid = 2'b01 one cycle later and adc_data echoes in_data; all other outputs are 0.
- Arm with sync_mode = 1 and capture_length = 4, then raise adc_external_sync and stream continuous valid -> adc_valid stays 0 until SYNC_STAGES+1 cycles after the rise; exactly 4 valid beats follow; capture_done pulses with the 4th; sync_event_count = 1.
- sync_mode = 2 with an armed rising edge -> no capture; a subsequent falling edge -> capture starts. sync_mode = 0 -> the edge is ignored and the block stays ARMED.
- Gapped in_valid (1,0,1,0) during capture_length = 3 -> DONE is reached only after 3 valid beats; the idle cycles are not counted.
- adc_sync and a trigger in the same cycle while ARMED -> state FREE, count unchanged. adc_sync during CAPTURE -> ARMED and adc_rst_sync = 1.
- Reset asserted mid-capture -> next cycle: all outputs 0 and state FREE. A trigger held high through reset release produces no capture until the block is armed and a new edge arrives.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Capture/synchronisation controller between the TPL ADC formatter and the DMA interface.
// Arms on software sync, starts on a selected external-sync edge, and gates per-channel valid.
module ad_ip_jesd204_tpl_adc_capture_ctrl #(
  parameter int NUM_CHANNELS    = 1,
  parameter int DATA_PATH_WIDTH = 1,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int DMA_DATA_WIDTH  = NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE,
  parameter int SYNC_STAGES     = 2,
  parameter int LENGTH_WIDTH    = 16,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      adc_sync,
  input  logic                      adc_external_sync,
  input  logic [1:0]                sync_mode,
  input  logic [LENGTH_WIDTH-1:0]   capture_length,
  input  logic [NUM_CHANNELS-1:0]   chan_enable,
  input  logic                      in_valid,
  input  logic [DMA_DATA_WIDTH-1:0] in_data,
  output logic [NUM_CHANNELS-1:0]   adc_valid,
  output logic [DMA_DATA_WIDTH-1:0] adc_data,
  output logic                      adc_sync_status,
  output logic                      adc_rst_sync,
  output logic                      capture_done,
  output logic [COUNT_WIDTH-1:0]    sync_event_count
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [LENGTH_WIDTH-1:0] beat_cnt, beat_cnt_nxt;
  logic [COUNT_WIDTH-1:0]  evt_cnt, evt_cnt_nxt;
  logic                    done_nxt;
  logic [SYNC_STAGES-1:0]  sync_p;
  logic                    sync_hist;
  logic                    trigger;
  logic                    gate_open;
  logic                    last_beat;

  function automatic logic edge_sel(input logic [1:0] mode, input logic cur, input logic prev);
    case (mode)
      2'd1:    return cur & ~prev;
      2'd2:    return ~cur & prev;
      2'd3:    return cur ^ prev;
      default: return 1'b0;
    endcase
  endfunction

  // Stage: external-sync synchroniser and edge history, running in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p    <= '0;
      sync_hist <= 1'b0;
    end else begin
      sync_p    <= {sync_p[SYNC_STAGES-2:0], adc_external_sync};
      sync_hist <= sync_p[SYNC_STAGES-1];
    end
  end

  assign trigger   = edge_sel(sync_mode, sync_p[SYNC_STAGES-1], sync_hist);
  assign gate_open = (state == ST_FREE) || (state == ST_CAPTURE);
  assign last_beat = in_valid && (capture_length != '0) &&
                     (beat_cnt == capture_length - LEN_ONE);

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    evt_cnt_nxt  = evt_cnt;
    done_nxt     = 1'b0;
    case (state)
      ST_FREE, ST_DONE: begin
        if (adc_sync) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // Software disarm takes priority over a coincident trigger
        if (adc_sync) begin
          state_nxt = ST_FREE;
        end else if (trigger) begin
          state_nxt    = ST_CAPTURE;
          beat_cnt_nxt = '0;
          evt_cnt_nxt  = evt_cnt + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        if (adc_sync) begin
          state_nxt    = ST_ARMED;
          beat_cnt_nxt = '0;
        end else if (last_beat) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else if (in_valid && (capture_length != '0)) begin
          beat_cnt_nxt = beat_cnt + LEN_ONE;
        end
      end
      default: state_nxt = ST_FREE;
    endcase
  end

  // Stage: control state, counters and the one-cycle output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_FREE;
      beat_cnt     <= '0;
      evt_cnt      <= '0;
      capture_done <= 1'b0;
      adc_valid    <= '0;
      adc_data     <= '0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_cnt_nxt;
      evt_cnt      <= evt_cnt_nxt;
      capture_done <= done_nxt;
      adc_valid    <= {NUM_CHANNELS{in_valid & gate_open}} & chan_enable;
      adc_data     <= in_data;
    end
  end

  assign adc_sync_status  = (state == ST_ARMED);
  assign adc_rst_sync     = (state == ST_ARMED);
  assign sync_event_count = evt_cnt;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Directed and randomized bench for the ADC capture controller, checked every cycle
// against a cycle-level behavioural model of the capture rules.
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int S   = 3;
  localparam int LW  = 16;
  localparam int CW  = 8;

  localparam int M_FREE = 0, M_ARMED = 1, M_CAPTURE = 2, M_DONE = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           adc_sync;
  logic           adc_external_sync;
  logic [1:0]     sync_mode;
  logic [LW-1:0]  capture_length;
  logic [NCH-1:0] chan_enable;
  logic           in_valid;
  logic [DW-1:0]  in_data;
  logic [NCH-1:0] adc_valid;
  logic [DW-1:0]  adc_data;
  logic           adc_sync_status;
  logic           adc_rst_sync;
  logic           capture_done;
  logic [CW-1:0]  sync_event_count;

  ad_ip_jesd204_tpl_adc_capture_ctrl #(
    .NUM_CHANNELS(NCH), .DATA_PATH_WIDTH(1), .BITS_PER_SAMPLE(16), .DMA_DATA_WIDTH(DW),
    .SYNC_STAGES(S), .LENGTH_WIDTH(LW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .adc_sync(adc_sync), .adc_external_sync(adc_external_sync),
    .sync_mode(sync_mode), .capture_length(capture_length), .chan_enable(chan_enable),
    .in_valid(in_valid), .in_data(in_data), .adc_valid(adc_valid), .adc_data(adc_data),
    .adc_sync_status(adc_sync_status), .adc_rst_sync(adc_rst_sync),
    .capture_done(capture_done), .sync_event_count(sync_event_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int beats = 0;
  int dones = 0;

  // Reference model: spec-level state, number of beats taken, trigger count,
  // and a queue holding past external-sync samples (index 0 = newest edge).
  int             m_state;
  int             m_beats;
  logic [CW-1:0]  m_evt;
  logic           ext_q[$];
  logic [NCH-1:0] e_valid;
  logic [DW-1:0]  e_data;
  logic           e_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_FREE;
    m_beats = 0;
    m_evt   = '0;
    ext_q   = {};
    for (int i = 0; i <= S; i++) ext_q.push_back(1'b0);
  endtask

  task automatic model_edge();
    logic s, h, trig;
    if (reset) begin
      model_reset();
      e_valid = '0;
      e_data  = '0;
      e_done  = 1'b0;
      return;
    end
    // Synchronised level is the sample taken S edges ago; history is one older
    s = ext_q[S-1];
    h = ext_q[S];
    case (sync_mode)
      2'd1:    trig = s && !h;
      2'd2:    trig = !s && h;
      2'd3:    trig = s != h;
      default: trig = 1'b0;
    endcase
    e_valid = (in_valid && (m_state == M_FREE || m_state == M_CAPTURE)) ? chan_enable : '0;
    e_data  = in_data;
    e_done  = 1'b0;
    case (m_state)
      M_FREE, M_DONE: if (adc_sync) m_state = M_ARMED;
      M_ARMED: begin
        if (adc_sync) m_state = M_FREE;
        else if (trig) begin
          m_state = M_CAPTURE;
          m_beats = 0;
          m_evt   = m_evt + 8'd1;
        end
      end
      default: begin
        if (adc_sync) begin
          m_state = M_ARMED;
          m_beats = 0;
        end else if (in_valid && capture_length != 0) begin
          m_beats = m_beats + 1;
          if (m_beats == int'(capture_length)) begin
            m_state = M_DONE;
            e_done  = 1'b1;
          end
        end
      end
    endcase
    ext_q.push_front(adc_external_sync);
    void'(ext_q.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("adc_valid", 64'(adc_valid), 64'(e_valid));
    chk("adc_data", 64'(adc_data), 64'(e_data));
    chk("adc_sync_status", 64'(adc_sync_status), 64'(m_state == M_ARMED));
    chk("adc_rst_sync", 64'(adc_rst_sync), 64'(m_state == M_ARMED));
    chk("capture_done", 64'(capture_done), 64'(e_done));
    chk("sync_event_count", 64'(sync_event_count), 64'(m_evt));
    if (adc_valid != '0) beats++;
    if (capture_done) dones++;
    in_data = $urandom;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_sync();
    adc_sync = 1'b1;
    step();
    adc_sync = 1'b0;
  endtask

  initial begin
    int first;
    reset = 1'b1; adc_sync = 1'b0; adc_external_sync = 1'b0; sync_mode = 2'd0;
    capture_length = '0; chan_enable = 2'b01; in_valid = 1'b1; in_data = $urandom;
    model_reset();

    run(2);
    chk("reset_valid", 64'(adc_valid), 64'd0);
    chk("reset_data", 64'(adc_data), 64'd0);

    // Free-run passthrough
    reset = 1'b0;
    run(1);
    chk("free_valid", 64'(adc_valid), 64'd1);
    run(4);

    // Bounded capture of 4 beats on a rising edge
    sync_mode = 2'd1; capture_length = 16'd4;
    pulse_sync();
    chk("armed_status", 64'(adc_sync_status), 64'd1);
    run(2);
    adc_external_sync = 1'b1;
    beats = 0; dones = 0; first = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (adc_valid != '0 && first < 0) first = k;
    end
    chk("trig_latency", 64'(first), 64'(S + 2));
    chk("cap_beats", 64'(beats), 64'd4);
    chk("cap_dones", 64'(dones), 64'd1);
    chk("evt_count_1", 64'(sync_event_count), 64'd1);

    // Falling-edge mode ignores a rise, captures on the fall
    adc_external_sync = 1'b0;
    run(S + 2);
    sync_mode = 2'd2;
    pulse_sync();
    adc_external_sync = 1'b1;
    run(S + 3);
    chk("mode2_rise_ignored", 64'(adc_sync_status), 64'd1);
    adc_external_sync = 1'b0;
    run(S + 3);
    chk("mode2_fall_capture", 64'(adc_sync_status), 64'd0);
    chk("evt_count_2", 64'(sync_event_count), 64'd2);
    pulse_sync();
    chk("abort_rst_sync", 64'(adc_rst_sync), 64'd1);

    // Mode 0 never leaves ARMED on an edge
    sync_mode = 2'd0;
    adc_external_sync = 1'b1;
    run(S + 3);
    adc_external_sync = 1'b0;
    run(S + 3);
    chk("mode0_armed", 64'(adc_sync_status), 64'd1);
    chk("evt_count_3", 64'(sync_event_count), 64'd2);

    // Gapped valid with capture_length 3, either-edge trigger
    chan_enable = 2'b11; capture_length = 16'd3; sync_mode = 2'd3;
    adc_external_sync = 1'b1;
    beats = 0; dones = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid = (k % 2) == 0;
      step();
    end
    in_valid = 1'b1;
    chk("gap_beats", 64'(beats), 64'd3);
    chk("gap_dones", 64'(dones), 64'd1);

    // adc_sync coincident with a trigger while ARMED
    sync_mode = 2'd1;
    adc_external_sync = 1'b0;
    run(S + 2);
    pulse_sync();
    adc_external_sync = 1'b1;
    run(S);
    adc_sync = 1'b1;
    step();
    adc_sync = 1'b0;
    chk("collide_status", 64'(adc_sync_status), 64'd0);
    chk("collide_count", 64'(sync_event_count), 64'd3);
    run(S + 2);
    chk("collide_free", 64'(adc_sync_status), 64'd0);

    // Reset in the middle of an unlimited capture, trigger held through release
    capture_length = '0;
    adc_external_sync = 1'b0;
    run(S + 2);
    pulse_sync();
    adc_external_sync = 1'b1;
    run(S + 4);
    chk("pre_reset_count", 64'(sync_event_count), 64'd4);
    reset = 1'b1;
    run(1);
    chk("midrst_valid", 64'(adc_valid), 64'd0);
    chk("midrst_data", 64'(adc_data), 64'd0);
    chk("midrst_count", 64'(sync_event_count), 64'd0);
    chk("midrst_done", 64'(capture_done), 64'd0);
    reset = 1'b0;
    run(S + 4);
    pulse_sync();
    run(S + 4);
    chk("stale_no_capture", 64'(adc_sync_status), 64'd1);
    adc_external_sync = 1'b0;
    run(S + 2);
    adc_external_sync = 1'b1;
    run(S + 2);
    chk("new_edge_capture", 64'(adc_sync_status), 64'd0);
    chk("new_edge_count", 64'(sync_event_count), 64'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      adc_sync = ($urandom % 12) == 0;
      if (($urandom % 4) == 0) adc_external_sync = ~adc_external_sync;
      if (($urandom % 40) == 0) sync_mode = 2'($urandom);
      in_valid    = ($urandom % 3) != 0;
      chan_enable = 2'($urandom);
      if (m_state == M_FREE || m_state == M_DONE) capture_length = 16'($urandom % 6);
      reset = ($urandom % 150) == 0;
      step();
    end
    reset = 1'b0; adc_sync = 1'b0;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
